seq_mul8_ctrl: RTL

Iterative shift-add multiplier controller for the approximate-multiplier datapath. It time-shares one WIDTH-bit adder row, built from half- and full-adder cells, over WIDTH cycles to form an unsigned WIDTH×WIDTH product. It owns the start/busy/done handshake. It also sequences an optional approximate mode, in which the low APPROX_K adder columns act as a carry-free lower-part OR adder (LOA).

---
 rtl/seq_mul8_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/seq_mul8_ctrl.sv
// Iterative shift-add multiplier controller: one WIDTH-bit adder row reused over
// WIDTH cycles, with an optional lower-part OR adder (LOA) on the low APPROX_K columns.
module seq_mul8_ctrl #(
  parameter int WIDTH    = 8,
  parameter int APPROX_K = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 approx,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [1:0]           state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   a_r;
  logic               mode_r;
  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] p_next;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   p_hi;
  logic [WIDTH-1:0]   pp;
  logic [WIDTH:0]     s;
  logic               carry;
  logic               accept;
  logic               last;

  // Handshake: start is a request accepted only in IDLE or DONE; busy is high
  // for the WIDTH RUN cycles; done pulses for one cycle with product valid.
  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (state == RUN) && (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start ? RUN : IDLE;
      RUN:     state_next = last ? DONE : RUN;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == RUN);
    done      = (state == DONE);
    state_dbg = state;
  end

  // One adder row: LOA columns below APPROX_K in approx mode, ripple elsewhere.
  always_comb begin
    p_hi  = p[2*WIDTH-1:WIDTH];
    pp    = p[0] ? a_r : '0;
    s     = '0;
    carry = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (mode_r && (i < APPROX_K)) begin
        s[i]  = p_hi[i] | pp[i];
        carry = (i == APPROX_K - 1) ? (p_hi[i] & pp[i]) : 1'b0;
      end else begin
        s[i]  = p_hi[i] ^ pp[i] ^ carry;
        carry = (p_hi[i] & pp[i]) | (carry & (p_hi[i] ^ pp[i]));
      end
    end
    s[WIDTH] = carry;
    p_next   = {s, p[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      mode_r  <= 1'b0;
      p       <= '0;
      count   <= '0;
      product <= '0;
    end else if (accept) begin
      a_r    <= a;
      mode_r <= approx;
      p      <= {{WIDTH{1'b0}}, b};
      count  <= '0;
    end else if (state == RUN) begin
      p     <= p_next;
      count <= count + CW'(1);
      if (last) product <= p_next;
    end
  end

endmodule
